receptor_quadro_peso: RTL and testbench

RECEPTOR_QUADRO_PESO -- requirements
Module: receptor_quadro_peso

---
 rtl/receptor_quadro_peso_pkg.sv | 23 ++
 rtl/acumulador_decimal.sv | 28 ++
 rtl/receptor_quadro_peso.sv | 180 ++++++++++++++++++
 tb/tb_receptor_quadro_peso.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/receptor_quadro_peso_pkg.sv
// Shared constants and state encoding for the weight frame receiver.
package receptor_quadro_peso_pkg;

  localparam int unsigned ACC_W = 16;

  localparam logic [7:0] ASCII_INICIO = 8'h23;
  localparam logic [7:0] ASCII_FIM    = 8'h0A;
  localparam logic [7:0] ASCII_ZERO   = 8'h30;
  localparam logic [7:0] ASCII_NOVE   = 8'h39;

  typedef enum logic [3:0] {
    ESPERA      = 4'd0,
    CAMPO_MAX   = 4'd1,
    CAMPO_MIN   = 4'd2,
    CAMPO_ATUAL = 4'd3,
    FIM         = 4'd4
  } estado_t;

  function automatic logic ehDigito(input logic [7:0] b);
    return (b >= ASCII_ZERO) && (b <= ASCII_NOVE);
  endfunction

endpackage

// File: rtl/acumulador_decimal.sv
// Decimal digit accumulator: value <= value*10 + digit, with synchronous clear.
module acumulador_decimal
  import receptor_quadro_peso_pkg::*;
(
  input  logic             clock,
  input  logic             reset,
  input  logic             limpa,
  input  logic             soma,
  input  logic [3:0]       digito,
  output logic [ACC_W-1:0] proximo_c
);

  logic [ACC_W-1:0] valor;

  // Times ten as shift-add; wraps at 16 bits.
  assign proximo_c = (valor << 3) + (valor << 1) + ACC_W'(digito);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      valor <= '0;
    end else if (limpa) begin
      valor <= '0;
    end else if (soma) begin
      valor <= proximo_c;
    end
  end

endmodule

// File: rtl/receptor_quadro_peso.sv
// Parses "#<max><min><atual>\n" ASCII frames from a UART byte stream into
// three binary weights, with resync on '#' and an inter-byte timeout.
module receptor_quadro_peso
  import receptor_quadro_peso_pkg::*;
#(
  parameter int unsigned DIGITOS = 4,
  parameter int unsigned TIMEOUT = 43400
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             dado_valido,
  input  logic [7:0]       dado,
  output logic [ACC_W-1:0] peso_max,
  output logic [ACC_W-1:0] peso_min,
  output logic [ACC_W-1:0] peso_atual,
  output logic             quadro_pronto,
  output logic             erro_quadro,
  output logic             ocupado,
  output logic [3:0]       db_estado
);

  localparam int unsigned CONT_W  = 3;
  localparam int unsigned TEMPO_W = $clog2(TIMEOUT + 1);
  localparam logic [CONT_W-1:0]  ULTIMO_DIGITO = CONT_W'(DIGITOS - 1);
  localparam logic [TEMPO_W-1:0] LIMITE_TEMPO  = TEMPO_W'(TIMEOUT - 1);

  estado_t             estado, estadoProx;
  logic [CONT_W-1:0]   contDigito, contDigitoProx;
  logic [TEMPO_W-1:0]  contTempo;
  logic [ACC_W-1:0]    sombraMax, sombraMin, sombraAtual;
  logic [ACC_W-1:0]    accProximo;
  logic                accLimpa, accSoma;
  logic                salvaMax, salvaMin, salvaAtual;
  logic                prontoProx, erroProx;
  logic                tempoEsgotado;

  acumulador_decimal uAcumulador (
    .clock     (clock),
    .reset     (reset),
    .limpa     (accLimpa),
    .soma      (accSoma),
    .digito    (4'(dado - ASCII_ZERO)),
    .proximo_c (accProximo)
  );

  assign tempoEsgotado = (estado != ESPERA) && (contTempo == LIMITE_TEMPO);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      estado     <= ESPERA;
      contDigito <= '0;
    end else begin
      estado     <= estadoProx;
      contDigito <= contDigitoProx;
    end
  end

  always_comb begin
    estadoProx     = estado;
    contDigitoProx = contDigito;
    accLimpa       = 1'b0;
    accSoma        = 1'b0;
    salvaMax       = 1'b0;
    salvaMin       = 1'b0;
    salvaAtual     = 1'b0;
    prontoProx     = 1'b0;
    erroProx       = 1'b0;

    if (dado_valido) begin
      case (estado)
        ESPERA: begin
          if (dado == ASCII_INICIO) begin
            estadoProx     = CAMPO_MAX;
            accLimpa       = 1'b1;
            contDigitoProx = '0;
          end
        end
        CAMPO_MAX, CAMPO_MIN, CAMPO_ATUAL: begin
          if (ehDigito(dado)) begin
            if (contDigito == ULTIMO_DIGITO) begin
              // Last digit goes straight to the shadow register.
              accLimpa       = 1'b1;
              contDigitoProx = '0;
              case (estado)
                CAMPO_MAX: begin
                  salvaMax   = 1'b1;
                  estadoProx = CAMPO_MIN;
                end
                CAMPO_MIN: begin
                  salvaMin   = 1'b1;
                  estadoProx = CAMPO_ATUAL;
                end
                default: begin
                  salvaAtual = 1'b1;
                  estadoProx = FIM;
                end
              endcase
            end else begin
              accSoma        = 1'b1;
              contDigitoProx = contDigito + CONT_W'(1);
            end
          end else begin
            erroProx       = 1'b1;
            accLimpa       = 1'b1;
            contDigitoProx = '0;
            estadoProx     = (dado == ASCII_INICIO) ? CAMPO_MAX : ESPERA;
          end
        end
        FIM: begin
          if (dado == ASCII_FIM) begin
            prontoProx = 1'b1;
            estadoProx = ESPERA;
          end else begin
            erroProx       = 1'b1;
            accLimpa       = 1'b1;
            contDigitoProx = '0;
            estadoProx     = (dado == ASCII_INICIO) ? CAMPO_MAX : ESPERA;
          end
        end
        default: begin
          estadoProx     = ESPERA;
          accLimpa       = 1'b1;
          contDigitoProx = '0;
        end
      endcase
    end else if (tempoEsgotado) begin
      erroProx       = 1'b1;
      accLimpa       = 1'b1;
      contDigitoProx = '0;
      estadoProx     = ESPERA;
    end
  end

  // Inter-byte silence counter.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      contTempo <= '0;
    end else if (dado_valido || (estado == ESPERA)) begin
      contTempo <= '0;
    end else begin
      contTempo <= contTempo + TEMPO_W'(1);
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sombraMax   <= '0;
      sombraMin   <= '0;
      sombraAtual <= '0;
    end else begin
      if (salvaMax)   sombraMax   <= accProximo;
      if (salvaMin)   sombraMin   <= accProximo;
      if (salvaAtual) sombraAtual <= accProximo;
    end
  end

  // Weights change only on an accepted terminator.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      peso_max      <= '0;
      peso_min      <= '0;
      peso_atual    <= '0;
      quadro_pronto <= 1'b0;
      erro_quadro   <= 1'b0;
      ocupado       <= 1'b0;
      db_estado     <= '0;
    end else begin
      if (prontoProx) begin
        peso_max   <= sombraMax;
        peso_min   <= sombraMin;
        peso_atual <= sombraAtual;
      end
      quadro_pronto <= prontoProx;
      erro_quadro   <= erroProx;
      ocupado       <= (estadoProx != ESPERA);
      db_estado     <= estadoProx;
    end
  end

endmodule

// File: tb/tb_receptor_quadro_peso.sv
// Scoreboard bench for receptor_quadro_peso: expected frames queued at send,
// checked when quadro_pronto fires.
module tb_receptor_quadro_peso;

  localparam int unsigned DIGITOS = 4;
  localparam int unsigned TIMEOUT = 40;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        dado_valido = 1'b0;
  logic [7:0]  dado = 8'h00;
  logic [15:0] peso_max, peso_min, peso_atual;
  logic        quadro_pronto, erro_quadro, ocupado;
  logic [3:0]  db_estado;

  typedef struct packed {
    logic [15:0] mx;
    logic [15:0] mn;
    logic [15:0] at;
  } quadro_t;

  quadro_t fila[$];
  quadro_t ultimo = '0;
  int      nTestes = 0;
  int      nFalhas = 0;
  int      nErros = 0;
  logic    fimAmostrado;

  always #5 clock = ~clock;

  receptor_quadro_peso #(.DIGITOS(DIGITOS), .TIMEOUT(TIMEOUT)) dut (
    .clock         (clock),
    .reset         (reset),
    .dado_valido   (dado_valido),
    .dado          (dado),
    .peso_max      (peso_max),
    .peso_min      (peso_min),
    .peso_atual    (peso_atual),
    .quadro_pronto (quadro_pronto),
    .erro_quadro   (erro_quadro),
    .ocupado       (ocupado),
    .db_estado     (db_estado)
  );

  task automatic verifica(input string tag, input logic [31:0] obs, input logic [31:0] esp);
    nTestes++;
    if (obs !== esp) begin
      nFalhas++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, esp);
    end
  endtask

  task automatic enviaByte(input logic [7:0] b);
    @(negedge clock);
    dado        = b;
    dado_valido = 1'b1;
    @(negedge clock);
    dado_valido = 1'b0;
  endtask

  task automatic enviaTexto(input string s);
    for (int i = 0; i < s.len(); i++) enviaByte(s[i]);
  endtask

  task automatic espera(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic confereInalterado(input string tag);
    verifica({tag, "_max"}, 32'(peso_max), 32'(ultimo.mx));
    verifica({tag, "_min"}, 32'(peso_min), 32'(ultimo.mn));
    verifica({tag, "_atual"}, 32'(peso_atual), 32'(ultimo.at));
  endtask

  // Monitor: pulse sanity, pulse latency and scoreboard compare.
  always @(posedge clock) begin
    quadro_t esp;
    fimAmostrado = dado_valido && (dado == 8'h0A);
    #1;
    if (quadro_pronto && erro_quadro) verifica("pronto_e_erro", 32'd1, 32'd0);
    if (erro_quadro) nErros++;
    if (quadro_pronto) begin
      verifica("latencia_pronto", 32'(fimAmostrado), 32'd1);
      if (fila.size() == 0) begin
        verifica("pronto_inesperado", 32'd1, 32'd0);
      end else begin
        esp = fila.pop_front();
        verifica("peso_max", 32'(peso_max), 32'(esp.mx));
        verifica("peso_min", 32'(peso_min), 32'(esp.mn));
        verifica("peso_atual", 32'(peso_atual), 32'(esp.at));
        ultimo = esp;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    int ciclos;

    repeat (3) @(negedge clock);
    verifica("reset_max", 32'(peso_max), 32'd0);
    verifica("reset_atual", 32'(peso_atual), 32'd0);
    verifica("reset_estado", 32'(db_estado), 32'd0);
    verifica("reset_ocupado", 32'(ocupado), 32'd0);
    verifica("reset_pulsos", 32'(quadro_pronto | erro_quadro), 32'd0);
    reset = 1'b1;
    espera(2);

    // Basic frame.
    base = nErros;
    fila.push_back('{mx: 16'd500, mn: 16'd100, at: 16'd250});
    enviaTexto("#050001000250\n");
    espera(3);
    verifica("q1_fila", 32'(fila.size()), 32'd0);
    verifica("q1_erros", 32'(nErros - base), 32'd0);
    verifica("q1_ocupado", 32'(ocupado), 32'd0);

    // Leading garbage then full-scale values.
    base = nErros;
    fila.push_back('{mx: 16'h270F, mn: 16'h270F, at: 16'h270F});
    enviaTexto("xyz#999999999999\n");
    espera(3);
    verifica("q2_fila", 32'(fila.size()), 32'd0);
    verifica("q2_erros", 32'(nErros - base), 32'd0);

    // Bad byte in a field.
    base = nErros;
    enviaTexto("#0500");
    verifica("q3_estado_min", 32'(db_estado), 32'd2);
    enviaByte("A");
    espera(3);
    verifica("q3_erros", 32'(nErros - base), 32'd1);
    verifica("q3_ocupado", 32'(ocupado), 32'd0);
    confereInalterado("q3");

    // Resync on a second '#'.
    base = nErros;
    enviaTexto("#05");
    verifica("q4_estado_max", 32'(db_estado), 32'd1);
    verifica("q4_ocupado", 32'(ocupado), 32'd1);
    fila.push_back('{mx: 16'd10, mn: 16'd20, at: 16'd30});
    enviaTexto("#001000200030\n");
    espera(3);
    verifica("q4_erros", 32'(nErros - base), 32'd1);
    verifica("q4_fila", 32'(fila.size()), 32'd0);

    // Wrong terminator.
    base = nErros;
    enviaTexto("#000100020003");
    verifica("q5_estado_fim", 32'(db_estado), 32'd4);
    enviaByte("X");
    espera(3);
    verifica("q5_erros", 32'(nErros - base), 32'd1);
    confereInalterado("q5");

    // Inter-byte timeout.
    base = nErros;
    enviaTexto("#0");
    @(negedge clock);
    dado        = "5";
    dado_valido = 1'b1;
    @(posedge clock);
    #1;
    dado_valido = 1'b0;
    ciclos = 0;
    while ((ciclos < int'(TIMEOUT) + 20) && !erro_quadro) begin
      @(posedge clock);
      #1;
      ciclos++;
    end
    verifica("q6_ciclos", 32'(ciclos), 32'(TIMEOUT));
    verifica("q6_ocupado", 32'(ocupado), 32'd0);
    espera(3);
    verifica("q6_erros", 32'(nErros - base), 32'd1);
    confereInalterado("q6");

    // Reset mid-frame.
    base = nErros;
    enviaTexto("#0500");
    @(negedge clock);
    reset = 1'b0;
    #1;
    verifica("q7_max", 32'(peso_max), 32'd0);
    verifica("q7_min", 32'(peso_min), 32'd0);
    verifica("q7_estado", 32'(db_estado), 32'd0);
    verifica("q7_ocupado", 32'(ocupado), 32'd0);
    espera(3);
    reset  = 1'b1;
    ultimo = '0;
    espera(2);
    verifica("q7_erros", 32'(nErros - base), 32'd0);
    fila.push_back('{mx: 16'd1234, mn: 16'd456, at: 16'd789});
    enviaTexto("#123404560789\n");
    espera(3);
    verifica("q7_fila", 32'(fila.size()), 32'd0);
    verifica("q7_erros_fim", 32'(nErros - base), 32'd0);

    // All-zero frame.
    fila.push_back('{mx: 16'd0, mn: 16'd0, at: 16'd0});
    enviaTexto("#000000000000\n");
    espera(4);
    verifica("fila_final", 32'(fila.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", nTestes, nFalhas);
    $finish;
  end

endmodule
